ax_br_update_queue: RTL and testbench
=====================================

AX_BR_UPDATE_QUEUE -- requirements
Module: ax_br_update_queue

Interface
REQ-001 SHALL have parameter ISSUE_W, default 2, meaning the number of branch-result lanes from IntEx.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the queue entry count; it shall be a power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning the PC width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port br_valid, input, ISSUE_W bits: per-lane branch result valid.
REQ-007 SHALL have port br_taken, input, ISSUE_W bits: per-lane executed-taken.
REQ-008 SHALL have port br_is_ax, input, ISSUE_W bits: per-lane approximate-branch flag.
REQ-009 SHALL have port br_is_cond, input, ISSUE_W bits: per-lane conditional-branch flag.
REQ-010 SHALL have port br_addr, input, ISSUE_W*ADDR_W bits: per-lane branch PC; lane i occupies bits [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port br_next, input, ISSUE_W*ADDR_W bits: per-lane resolved target, packed the same way as br_addr.
REQ-012 SHALL have port flush, input, 1 bit: synchronous queue clear.
REQ-013 SHALL have port upd_valid, output, 1 bit: head entry available for the AX BTB write.
REQ-014 SHALL have port upd_ready, input, 1 bit: the AX BTB accepts the head this cycle.
REQ-015 SHALL have port upd_br_addr, output, ADDR_W bits: head branch PC.
REQ-016 SHALL have port upd_next_addr, output, ADDR_W bits: head target.
REQ-017 SHALL have port upd_is_cond, output, 1 bit: head conditional flag.
REQ-018 SHALL have port count, output, $clog2(DEPTH)+1 bits: occupied entries.
REQ-019 SHALL have port full, output, 1 bit: count == DEPTH.
REQ-020 SHALL have port drop_count, output, 16 bits: saturating count of discarded candidates.

Function
REQ-021 SHALL treat lane i as a candidate iff br_valid[i] & br_taken[i] & br_is_ax[i].
REQ-022 SHALL suppress, within one cycle, candidate i if any higher lane j>i is a candidate with an equal br_addr; the youngest lane wins, and a suppressed lane is not counted as a drop.
REQ-023 SHALL define pop = upd_valid & upd_ready.
REQ-024 SHALL define free = DEPTH - count + pop, so a same-cycle pop frees a slot for a push.
REQ-025 SHALL enqueue surviving candidates in ascending lane order, at most free per cycle.
REQ-026 SHALL count each surviving candidate beyond free as a drop.
REQ-027 SHALL add all of that cycle's drops to drop_count, saturating at 16'hFFFF and never wrapping.
REQ-028 SHALL advance the tail pointer by the number of pushes and the head pointer by pop, both modulo DEPTH.
REQ-029 SHALL update count as count + pushes - pop.
REQ-030 SHALL NOT bypass: an entry enqueued in cycle N is first visible at the head in cycle N+1; an empty queue keeps upd_valid=0 even while candidates arrive.
REQ-031 SHALL assert upd_valid iff count != 0.
REQ-032 SHALL drive upd_br_addr, upd_next_addr and upd_is_cond from the head entry when upd_valid=1, and all-zero when upd_valid=0.
REQ-033 SHALL hold the head output stable while upd_valid=1 and upd_ready=0.
REQ-034 SHALL, on flush=1, set count=0 and equate head and tail at the next edge; that cycle's candidates are neither enqueued nor counted as drops, and drop_count is preserved.
REQ-035 SHALL give flush precedence over simultaneous push and pop.
REQ-036 SHALL preserve entry order across pointer wrap-around.
REQ-037 SHALL NOT change pointers or count on a pop attempt when empty (upd_valid=0 implies pop=0).

Reset
REQ-038 SHALL, while rst=0, immediately and asynchronously force head=tail=0, count=0, upd_valid=0, full=0, drop_count=0, and the upd_* data outputs to 0.
REQ-039 SHALL discard all in-flight entries on reset assertion mid-operation; entry storage needs no reset.
REQ-040 SHALL resume normal operation at the first rising edge after rst deasserts, starting from the empty state.

Verification
REQ-041 Single push: lane0 candidate, addr 0x1000, next 0x2000, upd_ready=0 -> next cycle upd_valid=1, upd_br_addr=0x1000, upd_next_addr=0x2000, count=1; raise upd_ready -> the following cycle upd_valid=0.
REQ-042 Duplicate: both lanes are candidates at addr 0x40, lane1 next=0x80 -> count=1 and the head shows next=0x80; drop_count stays 0.
REQ-043 Overflow: count=7, upd_ready=0, two candidates -> lane0 is enqueued, full=1, drop_count=1; repeating with upd_ready=1 -> one push, one pop, count stays 8 and drop_count=2.
REQ-044 Wrap-around: push and pop 13 distinct entries through DEPTH=8 -> the pop sequence matches the push order exactly and count returns to 0.
REQ-045 Flush collision: count=3, flush=1 with upd_ready=1 and two candidates -> next cycle count=0, upd_valid=0, drop_count unchanged.
REQ-046 Async reset: drop_count=5 and count=4, pull rst low mid-cycle -> without waiting for an edge, upd_valid=0, count=0, drop_count=0.

Source files
------------

// File: rtl/ax_br_update_queue.sv
// Collects taken approximate-branch results from IntEx lanes and queues them for the AX BTB write port.
// Latency: an entry pushed at edge N is at the head from cycle N+1; there is no bypass path.
// Backpressure: upd_valid/upd_ready handshake at the head; candidates beyond free slots are dropped and counted.
module ax_br_update_queue #(
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ISSUE_W-1:0]        br_valid,
  input  logic [ISSUE_W-1:0]        br_taken,
  input  logic [ISSUE_W-1:0]        br_is_ax,
  input  logic [ISSUE_W-1:0]        br_is_cond,
  input  logic [ISSUE_W*ADDR_W-1:0] br_addr,
  input  logic [ISSUE_W*ADDR_W-1:0] br_next,
  input  logic                      flush,
  output logic                      upd_valid,
  input  logic                      upd_ready,
  output logic [ADDR_W-1:0]         upd_br_addr,
  output logic [ADDR_W-1:0]         upd_next_addr,
  output logic                      upd_is_cond,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic [15:0]               drop_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int LANE_CW = $clog2(ISSUE_W + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] brAddr;
    logic [ADDR_W-1:0] nextAddr;
    logic              isCond;
  } brEntryT;

  brEntryT            mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   occ;
  logic [15:0]        drops;

  logic [ISSUE_W-1:0] cand;
  logic [ISSUE_W-1:0] survive;
  logic [ISSUE_W-1:0] wrEn;
  logic [PTR_W-1:0]   wrIdx [ISSUE_W];
  logic [CNT_W-1:0]   freeSlots;
  logic [CNT_W-1:0]   pushN;
  logic [LANE_CW-1:0] dropN;
  logic               pop;
  logic [16:0]        dropSum;
  brEntryT            headEntry;

  assign upd_valid     = (occ != '0);
  assign pop           = upd_valid & upd_ready;
  assign headEntry     = mem[head];
  assign upd_br_addr   = upd_valid ? headEntry.brAddr   : '0;
  assign upd_next_addr = upd_valid ? headEntry.nextAddr : '0;
  assign upd_is_cond   = upd_valid ? headEntry.isCond   : 1'b0;
  assign count         = occ;
  assign full          = (occ == CNT_W'(DEPTH));
  assign drop_count    = drops;
  assign freeSlots     = CNT_W'(DEPTH) - occ + CNT_W'(pop);
  assign dropSum       = {1'b0, drops} + 17'(dropN);

  // Candidate filtering (youngest lane wins on equal PC) and in-order slot allocation
  always_comb begin
    cand    = br_valid & br_taken & br_is_ax;
    survive = '0;
    wrEn    = '0;
    pushN   = '0;
    dropN   = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      wrIdx[i]   = tail + pushN[PTR_W-1:0];
      survive[i] = cand[i];
      for (int j = i + 1; j < ISSUE_W; j++) begin
        if (cand[j] && (br_addr[j*ADDR_W +: ADDR_W] == br_addr[i*ADDR_W +: ADDR_W]))
          survive[i] = 1'b0;
      end
      if (survive[i] && !flush) begin
        if (pushN < freeSlots) begin
          wrEn[i] = 1'b1;
          pushN   = pushN + CNT_W'(1);
        end else begin
          dropN = dropN + LANE_CW'(1);
        end
      end
    end
  end

  // Entry storage; contents are meaningless outside head..tail so no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < ISSUE_W; i++) begin
      if (wrEn[i]) begin
        mem[wrIdx[i]] <= '{brAddr:   br_addr[i*ADDR_W +: ADDR_W],
                           nextAddr: br_next[i*ADDR_W +: ADDR_W],
                           isCond:   br_is_cond[i]};
      end
    end
  end

  // Pointers, occupancy and saturating drop counter; flush overrides push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      occ   <= '0;
      drops <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      occ   <= '0;
    end else begin
      tail  <= tail + pushN[PTR_W-1:0];
      head  <= head + PTR_W'(pop);
      occ   <= occ + pushN - CNT_W'(pop);
      drops <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
    end
  end

endmodule

// File: tb/tb_ax_br_update_queue.sv
// Directed bench for ax_br_update_queue (ISSUE_W=2, DEPTH=8, ADDR_W=32).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Expected values are hand-computed constants plus a small FIFO model for the wrap run.
module tb_ax_br_update_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  br_valid, br_taken, br_is_ax, br_is_cond;
  logic [63:0] br_addr, br_next;
  logic        flush;
  logic        upd_valid, upd_ready, upd_is_cond, full;
  logic [31:0] upd_br_addr, upd_next_addr;
  logic [3:0]  count;
  logic [15:0] drop_count;

  int nTests = 0;
  int nFail  = 0;

  ax_br_update_queue #(.ISSUE_W(2), .DEPTH(8), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_taken(br_taken), .br_is_ax(br_is_ax), .br_is_cond(br_is_cond),
    .br_addr(br_addr), .br_next(br_next), .flush(flush),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_br_addr(upd_br_addr), .upd_next_addr(upd_next_addr), .upd_is_cond(upd_is_cond),
    .count(count), .full(full), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    br_valid = '0; br_taken = '0; br_is_ax = '0; br_is_cond = '0;
    br_addr = '0; br_next = '0;
  endtask

  task automatic setLane(input int l, input logic [31:0] a, input logic [31:0] n, input logic c);
    br_valid[l] = 1'b1; br_taken[l] = 1'b1; br_is_ax[l] = 1'b1; br_is_cond[l] = c;
    br_addr[l*32 +: 32] = a;
    br_next[l*32 +: 32] = n;
  endtask

  task automatic pushOne(input logic [31:0] a);
    setLane(0, a, a + 32'h10, 1'b0);
    tick();
    clearIn();
  endtask

  task automatic pushTwo(input logic [31:0] a0, input logic [31:0] a1);
    setLane(0, a0, a0 + 32'h10, 1'b0);
    setLane(1, a1, a1 + 32'h10, 1'b0);
    tick();
    clearIn();
  endtask

  logic [31:0] expQ[$];
  logic [31:0] ovfOrder [8];

  initial begin
    clearIn();
    flush = 1'b0; upd_ready = 1'b0; rst = 1'b0;

    // Reset state
    #12;
    checkVal("rst_valid", 32'(upd_valid), 32'd0);
    checkVal("rst_count", 32'(count), 32'd0);
    checkVal("rst_full", 32'(full), 32'd0);
    checkVal("rst_drop", 32'(drop_count), 32'd0);
    checkVal("rst_addr", upd_br_addr, 32'd0);
    rst = 1'b1;
    tick();

    // Single push, no bypass, hold under backpressure, then pop
    setLane(0, 32'h1000, 32'h2000, 1'b1);
    #1;
    checkVal("nobypass_valid", 32'(upd_valid), 32'd0);
    tick();
    clearIn();
    checkVal("single_valid", 32'(upd_valid), 32'd1);
    checkVal("single_addr", upd_br_addr, 32'h1000);
    checkVal("single_next", upd_next_addr, 32'h2000);
    checkVal("single_cond", 32'(upd_is_cond), 32'd1);
    checkVal("single_count", 32'(count), 32'd1);
    tick();
    checkVal("hold_addr", upd_br_addr, 32'h1000);
    checkVal("hold_count", 32'(count), 32'd1);
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
    checkVal("pop_valid", 32'(upd_valid), 32'd0);
    checkVal("pop_next_zero", upd_next_addr, 32'd0);

    // Non-candidates: valid but not taken / taken but not approximate
    br_valid = 2'b11; br_taken = 2'b10; br_is_ax = 2'b01;
    tick();
    clearIn();
    checkVal("noncand_count", 32'(count), 32'd0);

    // Duplicate PC within one cycle: lane1 wins, no drop
    setLane(0, 32'h40, 32'h44, 1'b0);
    setLane(1, 32'h40, 32'h80, 1'b0);
    tick();
    clearIn();
    checkVal("dup_count", 32'(count), 32'd1);
    checkVal("dup_next", upd_next_addr, 32'h80);
    checkVal("dup_drop", 32'(drop_count), 32'd0);
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;

    // Overflow: fill to 7, then two candidates with and without a same-cycle pop
    pushTwo(32'h100, 32'h104);
    pushTwo(32'h108, 32'h10C);
    pushTwo(32'h110, 32'h114);
    pushOne(32'h118);
    checkVal("ovf_count7", 32'(count), 32'd7);
    checkVal("ovf_notfull", 32'(full), 32'd0);
    setLane(0, 32'h200, 32'h210, 1'b0);
    setLane(1, 32'h204, 32'h214, 1'b0);
    tick();
    clearIn();
    checkVal("ovf_full", 32'(full), 32'd1);
    checkVal("ovf_count8", 32'(count), 32'd8);
    checkVal("ovf_drop1", 32'(drop_count), 32'd1);
    checkVal("ovf_head", upd_br_addr, 32'h100);
    setLane(0, 32'h300, 32'h310, 1'b0);
    setLane(1, 32'h304, 32'h314, 1'b0);
    upd_ready = 1'b1;
    tick();
    clearIn();
    upd_ready = 1'b0;
    checkVal("ovf_pop_count", 32'(count), 32'd8);
    checkVal("ovf_drop2", 32'(drop_count), 32'd2);
    ovfOrder = '{32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h200, 32'h300};
    upd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checkVal($sformatf("ovf_order%0d", k), upd_br_addr, ovfOrder[k]);
      tick();
    end
    checkVal("ovf_drained", 32'(count), 32'd0);
    // Pop attempt while empty must not disturb anything
    tick();
    upd_ready = 1'b0;
    checkVal("empty_pop_count", 32'(count), 32'd0);
    checkVal("empty_pop_valid", 32'(upd_valid), 32'd0);

    // Wrap-around: 13 entries streamed through, head checked against a FIFO model
    for (int c = 0; c < 17; c++) begin
      logic doPop;
      clearIn();
      if (c < 13) setLane(0, 32'h5000 + 32'(c) * 4, 32'(c), 1'b0);
      upd_ready = (c >= 3);
      #1;
      if (expQ.size() > 0) begin
        checkVal($sformatf("wrap_head%0d", c), upd_br_addr, expQ[0]);
      end
      doPop = upd_ready && (expQ.size() > 0);
      tick();
      if (doPop) void'(expQ.pop_front());
      if (c < 13) expQ.push_back(32'h5000 + 32'(c) * 4);
    end
    clearIn();
    upd_ready = 1'b0;
    checkVal("wrap_count", 32'(count), 32'd0);
    checkVal("wrap_model_empty", 32'(expQ.size()), 32'd0);

    // Flush collides with pop and two candidates
    pushTwo(32'h600, 32'h604);
    pushOne(32'h608);
    checkVal("flush_pre_count", 32'(count), 32'd3);
    flush = 1'b1;
    upd_ready = 1'b1;
    setLane(0, 32'h700, 32'h710, 1'b0);
    setLane(1, 32'h704, 32'h714, 1'b0);
    tick();
    clearIn();
    flush = 1'b0;
    upd_ready = 1'b0;
    checkVal("flush_count", 32'(count), 32'd0);
    checkVal("flush_valid", 32'(upd_valid), 32'd0);
    checkVal("flush_drop", 32'(drop_count), 32'd2);
    pushOne(32'h800);
    checkVal("postflush_head", upd_br_addr, 32'h800);
    checkVal("postflush_count", 32'(count), 32'd1);
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;

    // Build drop_count=5, count=4, then assert reset mid-cycle
    pushTwo(32'h900, 32'h904);
    pushTwo(32'h908, 32'h90C);
    pushTwo(32'h910, 32'h914);
    pushTwo(32'h918, 32'h91C);
    pushTwo(32'h920, 32'h924);
    pushOne(32'h928);
    upd_ready = 1'b1;
    repeat (4) tick();
    upd_ready = 1'b0;
    checkVal("pre_rst_count", 32'(count), 32'd4);
    checkVal("pre_rst_drop", 32'(drop_count), 32'd5);
    checkVal("pre_rst_head", upd_br_addr, 32'h910);
    #3;
    rst = 1'b0;
    #1;
    checkVal("arst_valid", 32'(upd_valid), 32'd0);
    checkVal("arst_count", 32'(count), 32'd0);
    checkVal("arst_drop", 32'(drop_count), 32'd0);
    checkVal("arst_full", 32'(full), 32'd0);
    checkVal("arst_addr", upd_br_addr, 32'd0);
    #2;
    rst = 1'b1;
    tick();
    pushOne(32'hA00);
    checkVal("post_rst_head", upd_br_addr, 32'hA00);
    checkVal("post_rst_count", 32'(count), 32'd1);

    // Drop counter saturation
    pushTwo(32'hB00, 32'hB04);
    pushTwo(32'hB08, 32'hB0C);
    pushTwo(32'hB10, 32'hB14);
    pushOne(32'hB18);
    checkVal("sat_full", 32'(full), 32'd1);
    setLane(0, 32'hC00, 32'hC10, 1'b0);
    setLane(1, 32'hC04, 32'hC14, 1'b0);
    repeat (32767) tick();
    checkVal("sat_fffe", 32'(drop_count), 32'h0000FFFE);
    tick();
    checkVal("sat_ffff", 32'(drop_count), 32'h0000FFFF);
    tick();
    clearIn();
    checkVal("sat_hold", 32'(drop_count), 32'h0000FFFF);
    checkVal("sat_count", 32'(count), 32'd8);
    checkVal("sat_head", upd_br_addr, 32'hA00);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
